spi_cmd_master: RTL
===================

SPI_CMD_MASTER -- requirements
Module: spi_cmd_master

Interface
REQ-001 Parameter CLK_HALF, default 4, SPI clock half-period in clock_in cycles (>=1).
REQ-002 Parameter CSN_LEAD, default 8, cycles from spicsn fall to first spiclk rise minus CLK_HALF (>=1).
REQ-003 Parameter CSN_TRAIL, default 8, cycles from last spiclk fall to spicsn rise (>=1).
REQ-004 Parameter CSN_GAP, default 8, minimum spicsn-high cycles between transactions (>=1).
REQ-005 clock_in  input  1  single system clock; all logic on its rising edge.
REQ-006 reset_in  input  1  synchronous, active-low reset.
REQ-007 start  input  1  request a transaction; sampled only while idle.
REQ-008 cmd  input  8  command byte (0x10 write, 0x11 read; not interpreted by this block).
REQ-009 addr  input  8  register address byte.
REQ-010 wdata  input  16  write data; low half of the frame.
REQ-011 spicsn  output  1  chip select, active low.
REQ-012 spiclk  output  1  SPI clock, mode 0 (idle low).
REQ-013 spimosi  output  1  serial data out, MSB first.
REQ-014 spimiso  input  1  serial data in from the responder.
REQ-015 rdata  output  16  last 16 bits received in the most recent frame.
REQ-016 busy  output  1  high from start acceptance through end of GAP.
REQ-017 done  output  1  one-cycle pulse at frame completion.

Function
REQ-018 Frame SHALL be 32 bits {cmd, addr, wdata}, transmitted bit 31 first.
REQ-019 States SHALL be IDLE, LEAD, CLK_LO, CLK_HI, TRAIL, GAP.
REQ-020 IDLE, start=1 at edge N: latch frame into shift register; at edge N+1 spicsn=0, busy=1, spimosi=bit31, enter LEAD.
REQ-021 LEAD SHALL last CSN_LEAD cycles, then enter CLK_LO.
REQ-022 CLK_LO SHALL hold spiclk=0 for CLK_HALF cycles with spimosi stable, then enter CLK_HI.
REQ-023 On entry to CLK_HI, spiclk SHALL go 1 and spimiso SHALL be shifted into the receive register LSB in the same edge.
REQ-024 CLK_HI SHALL last CLK_HALF cycles; on exit spiclk=0, spimosi advances to next bit, bit counter increments.
REQ-025 After the 32nd CLK_HI, state SHALL be TRAIL, not CLK_LO; spimosi SHALL drive 0.
REQ-026 TRAIL SHALL last CSN_TRAIL cycles; on exit spicsn=1, rdata=receive[15:0], done=1 for that one cycle, enter GAP.
REQ-027 GAP SHALL last CSN_GAP cycles with busy=1; on exit busy=0, IDLE.
REQ-028 Exactly 32 spiclk rising edges per frame; spiclk SHALL never be high while spicsn=1.
REQ-029 start while busy=1 SHALL be ignored, not queued; cmd/addr/wdata changes after acceptance SHALL not affect the frame.
REQ-030 start held high continuously SHALL yield back-to-back frames separated by exactly CSN_GAP+1 spicsn-high cycles.
REQ-031 rdata SHALL hold its value between frames and change only at done.
REQ-032 Counters SHALL be sized for max(CLK_HALF, CSN_LEAD, CSN_TRAIL, CSN_GAP) and 32 bits without wrap.

Reset
REQ-033 reset_in=0 at any edge, including mid-frame: next state IDLE, spicsn=1, spiclk=0, spimosi=0, busy=0, done=0, rdata=0x0000, counters cleared.
REQ-034 A frame interrupted by reset SHALL not assert done nor update rdata.

Verification
REQ-035 Write: start with cmd=0x10, addr=0x01, wdata=0xAAAA -> bits sampled on 32 spiclk rises equal 0x1001AAAA; one done pulse.
REQ-036 Read: cmd=0x11, addr=0x01, wdata=0x0000, responder model drives 0x5555 in bits 15..0 -> rdata=0x5555 at done.
REQ-037 Timing, defaults: spicsn low duration = 8+32*8+8 = 272 cycles; busy duration = 281 cycles from acceptance edge.
REQ-038 start pulsed during CLK_HI of bit 10 -> ignored; single frame; done count 1.
REQ-039 reset_in=0 during bit 20 -> next edge spicsn=1, spiclk=0, busy=0; no done; rdata unchanged at 0x0000.
REQ-040 start held high for three frames -> spicsn-high gaps of exactly 9 cycles; three done pulses.

Source files
------------

// File: rtl/spi_cmd_master.sv
// SPI command master: shifts a 32-bit {cmd, addr, wdata} frame out in mode 0
// and captures the last 16 bits returned on spimiso into rdata.
module spi_cmd_master #(
  parameter int unsigned CLK_HALF  = 4,
  parameter int unsigned CSN_LEAD  = 8,
  parameter int unsigned CSN_TRAIL = 8,
  parameter int unsigned CSN_GAP   = 8
) (
  input  logic        clock_in,
  input  logic        reset_in,
  input  logic        start,
  input  logic [7:0]  cmd,
  input  logic [7:0]  addr,
  input  logic [15:0] wdata,
  output logic        spicsn,
  output logic        spiclk,
  output logic        spimosi,
  input  logic        spimiso,
  output logic [15:0] rdata,
  output logic        busy,
  output logic        done
);

  // LEAD counts 0..CSN_LEAD: its first cycle is the frame-latch cycle with
  // spicsn still high, so the counter must reach CSN_LEAD itself.
  localparam int unsigned MAX_A   = (CLK_HALF > CSN_LEAD + 1) ? CLK_HALF : CSN_LEAD + 1;
  localparam int unsigned MAX_B   = (CSN_TRAIL > CSN_GAP) ? CSN_TRAIL : CSN_GAP;
  localparam int unsigned CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {IDLE, LEAD, CLK_LO, CLK_HI, TRAIL, GAP} state_t;

  state_t         state;
  state_t         state_nxt;
  logic [CW-1:0]  cnt;
  logic [5:0]     bit_cnt;
  logic [31:0]    tx_sr;
  logic [15:0]    rx_sr;
  logic           phase_end;
  logic           load;
  logic           cs_active;

  // Last cycle of the current phase
  always_comb begin
    phase_end = 1'b0;
    case (state)
      LEAD:           phase_end = (cnt == CW'(CSN_LEAD));
      CLK_LO, CLK_HI: phase_end = (cnt == CW'(CLK_HALF - 1));
      TRAIL:          phase_end = (cnt == CW'(CSN_TRAIL - 1));
      GAP:            phase_end = (cnt == CW'(CSN_GAP - 1));
      default:        phase_end = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clock_in) begin
    if (!reset_in) state <= IDLE;
    else           state <= state_nxt;
  end

  // Next-state logic; a held start is taken at GAP exit so back-to-back
  // frames see spicsn high for exactly CSN_GAP+1 cycles.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = LEAD;
      LEAD:    if (phase_end) state_nxt = CLK_LO;
      CLK_LO:  if (phase_end) state_nxt = CLK_HI;
      CLK_HI:  if (phase_end) state_nxt = (bit_cnt == 6'd31) ? TRAIL : CLK_LO;
      TRAIL:   if (phase_end) state_nxt = GAP;
      GAP:     if (phase_end) state_nxt = start ? LEAD : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign load = (state_nxt == LEAD) && (state != LEAD);

  // Phase counter, shift registers and read-data capture
  always_ff @(posedge clock_in) begin
    if (!reset_in) begin
      cnt     <= '0;
      bit_cnt <= '0;
      tx_sr   <= '0;
      rx_sr   <= '0;
      rdata   <= '0;
    end else begin
      if ((state_nxt != state) || (state == IDLE)) cnt <= '0;
      else                                         cnt <= cnt + CW'(1);
      if (load) begin
        tx_sr   <= {cmd, addr, wdata};
        bit_cnt <= '0;
      end
      if ((state == CLK_LO) && phase_end) rx_sr <= {rx_sr[14:0], spimiso};
      if ((state == CLK_HI) && phase_end) begin
        tx_sr   <= {tx_sr[30:0], 1'b0};
        bit_cnt <= bit_cnt + 6'd1;
      end
      if ((state == TRAIL) && phase_end) rdata <= rx_sr;
    end
  end

  // Moore outputs decoded from state and phase counter
  always_comb begin
    cs_active = ((state == LEAD) && (cnt != '0)) || (state == CLK_LO) ||
                (state == CLK_HI) || (state == TRAIL);
    spicsn    = ~cs_active;
    spiclk    = (state == CLK_HI);
    spimosi   = (cs_active && (state != TRAIL)) ? tx_sr[31] : 1'b0;
    busy      = (state != IDLE);
    done      = (state == GAP) && (cnt == '0);
  end

endmodule
